// File: rtl/alu_pkg.sv
// alu_pkg: shared state encodings, ALU opcode constants and default widths
package alu_pkg;
  localparam int N_BUS_DEF = 8;
  localparam int N_OP_DEF = 6;
  localparam logic [7:0] OP_ADD = 8'h20;
  localparam logic [7:0] OP_SUB = 8'h22;
  localparam logic [7:0] OP_AND = 8'h24;
  localparam logic [7:0] OP_OR  = 8'h25;
  localparam logic [7:0] OP_XOR = 8'h26;
  localparam logic [7:0] OP_SRA = 8'h03;
  localparam logic [7:0] OP_SRL = 8'h02;
  localparam logic [7:0] OP_NOR = 8'h27;
  typedef enum logic [2:0] {S_WAIT_A, S_WAIT_B, S_WAIT_OP, S_EXEC, S_SEND} state_t;
endpackage

// File: rtl/alu_rx_sequencer_idle_timer.sv
// idle_timer: counts enabled idle clocks, expire is high combinationally on the last allowed one
module idle_timer #(
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic expire
);
  localparam int W = TIMEOUT_CYC > 2 ? $clog2(TIMEOUT_CYC) : 1;
  logic [W-1:0] cnt;
  assign expire = en && cnt == W'(TIMEOUT_CYC - 1);
  always_ff @(posedge clk)
    cnt <= (rst || clear) ? '0 : en ? cnt + 1'b1 : cnt;
endmodule

// File: rtl/alu_rx_sequencer.sv
// alu_rx_sequencer: loads A, B, opcode from rx bytes into ALU operands and returns the ALU result byte to tx
module alu_rx_sequencer
  import alu_pkg::*;
#(
  parameter int N_BUS = N_BUS_DEF,
  parameter int N_OP = N_OP_DEF,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [7:0]       i_rx_data,
  input  logic             i_rx_valid,
  output logic [N_BUS-1:0] o_A,
  output logic [N_BUS-1:0] o_B,
  output logic [N_OP-1:0]  o_OP,
  input  logic [N_BUS-1:0] i_RES,
  output logic [7:0]       o_tx_data,
  output logic             o_tx_start,
  input  logic             i_tx_busy,
  output logic             o_busy,
  output logic             o_overrun,
  output logic             o_timeout
);
  state_t state, next;
  logic [N_BUS-1:0] res_q;
  logic expire;
  assign o_busy = state inside {S_EXEC, S_SEND};
  idle_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_idle_timer (
    .clk(i_clk),
    .rst(i_reset),
    .clear(next != state),
    .en(state inside {S_WAIT_B, S_WAIT_OP}),
    .expire(expire)
  );
  always_comb begin
    next = state;
    unique case (state)
      S_WAIT_A:  next = i_rx_valid ? S_WAIT_B : state;
      S_WAIT_B:  next = i_rx_valid ? S_WAIT_OP : expire ? S_WAIT_A : state;
      S_WAIT_OP: next = i_rx_valid ? S_EXEC : expire ? S_WAIT_A : state;
      S_EXEC:    next = S_SEND;
      S_SEND:    next = i_tx_busy ? state : S_WAIT_A;
      default:   next = S_WAIT_A;
    endcase
  end
  always_ff @(posedge i_clk)
    state <= i_reset ? S_WAIT_A : next;
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_A <= '0;
      o_B <= '0;
      o_OP <= '0;
      res_q <= '0;
      o_tx_data <= '0;
      o_tx_start <= 1'b0;
      o_overrun <= 1'b0;
      o_timeout <= 1'b0;
    end else begin
      o_tx_start <= state == S_SEND && !i_tx_busy;
      o_timeout <= expire && !i_rx_valid;
      if (state == S_WAIT_A && i_rx_valid) o_A <= i_rx_data[N_BUS-1:0];
      if (state == S_WAIT_B && i_rx_valid) o_B <= i_rx_data[N_BUS-1:0];
      if (state == S_WAIT_OP && i_rx_valid) o_OP <= i_rx_data[N_OP-1:0];
      if (state == S_EXEC) res_q <= i_RES;
      if (state == S_SEND && !i_tx_busy) o_tx_data <= 8'(res_q);
      if (o_busy && i_rx_valid) o_overrun <= 1'b1;
    end
  end
endmodule
